ws2812_rx: RTL and testbench
============================

// Module: ws2812_rx
// PURPOSE
//   Receive-side decoder for the WS2812 one-wire protocol. Samples ws_data,
//   classifies each high pulse as a 0/1 bit by width, and assembles 24-bit
//   GRB words tagged with their LED index. Detects the low reset gap as the
//   frame latch. Used as a loopback checker for ws2812 and as a frame sniffer.
// PARAMETERS
//   NUM_LEDS      100  max words accepted per frame; later words are errors
//   MIN_HIGH      2    high pulses shorter than this (clk) are glitches
//   BIT_THRESH    6    high width >= BIT_THRESH decodes as 1, else 0
//   MAX_HIGH      24   high width > MAX_HIGH is a stuck-high timeout
//   RESET_CYCLES  600  low run of this many clk ends the frame (50us @12MHz)
// PORTS
//   clk        in   1   system clock
//   reset      in   1   asynchronous, active-high reset
//   ws_data    in   1   serial line, asynchronous to clk
//   rgb_data   out  24  last decoded word, first bit received = bit 23
//   led_num    out  8   index of the word in rgb_data, 0-based within frame
//   valid      out  1   1-clk pulse: rgb_data/led_num updated this cycle
//   latch      out  1   1-clk pulse: reset gap seen, frame complete
//   frame_len  out  8   words accepted in the last completed frame
//   error      out  1   1-clk pulse on any protocol error
//   err_code   out  2   0 GLITCH, 1 TIMEOUT, 2 PARTIAL, 3 OVERFLOW; holds
// BEHAVIOUR
//   - Reset: every output 0; bit count, word count, counters cleared;
//     low counter cleared and "frame active" flag clear.
//   - ws_data -> 2-flop sync -> 1 delay flop; rise/fall from sync/delay pair.
//   - High counter: cleared on rise, +1 per clk while high, saturates at
//     MAX_HIGH+1. Low counter: cleared on rise, +1 while low, sat RESET_CYCLES.
//   - On fall: w<MIN_HIGH -> GLITCH, bit dropped; w>=BIT_THRESH -> shift 1;
//     else shift 0. Shift left into 24-bit reg; bit count 0..23.
//   - High counter reaching MAX_HIGH+1 -> TIMEOUT once, word aborted (bit
//     count 0); the eventual fall is then ignored.
//   - 24th bit: if word count < NUM_LEDS: rgb_data<=shift, led_num<=word
//     count, valid=1, word count+1; else OVERFLOW, discarded, led_num holds.
//   - Latency: valid/error register on the detected fall; pin-to-valid is 3
//     clk edges after the first edge sampling ws_data low.
//   - Any accepted bit sets "frame active". When the low counter reaches
//     RESET_CYCLES with frame active: latch=1, frame_len<=word count; PARTIAL
//     error same cycle if bit count!=0; bit count, word count, active clear.
//     Idle line never latches.
//   - A rise in the same cycle the low counter reaches RESET_CYCLES: latch
//     processed first, the rise starts the first bit of the next frame.
//   - Simultaneous errors in one cycle: err_code takes the higher code.
//   - Reset asserted mid-word/mid-frame: immediate clear; decode resumes on the
//     next rise with led_num 0.
// STRUCTURE
//   - ws2812_defs.vh (shared with ws2812): default T0H/T1H/reset-gap cycle
//     counts for 12 MHz, err_code localparams.
//   - Sub-module ws2812_pulse_meter: sync, edge detect, high/low counters;
//     emits bit_valid, bit_val, glitch, timeout, gap. ws2812_rx holds the
//     shift register, word/bit counters and output registers.
// TESTING
//   1 One frame, 24'h10_00_00, T0H=4/T1H=8/period 15, then 700 low -> one
//     valid, rgb_data=24'h100000, led_num=0, latch, frame_len=1, no error.
//   2 Loopback from ws2812 (NUM_LEDS=100), 4 colour cycles -> 100 valids per
//     frame, led_num 0..99 in order, rgb_data matches colour, frame_len=100.
//   3 101 words then gap -> 100 valids, OVERFLOW on word 101, frame_len=100.
//   4 12 bits then 700 low -> no valid, latch with PARTIAL error, frame_len=0.
//   5 1-clk high inside a word -> GLITCH, word still correct; 30-clk high ->
//     TIMEOUT, word aborted, following full word decodes with led_num 0.
//   6 reset pulsed 1 clk mid-word -> all outputs 0 at once; next frame
//     decodes from led_num 0 with correct data.

Source files
------------

// File: rtl/ws2812_rx_pkg.sv
// rtl/ws2812_rx_pkg.sv - shared WS2812 receive constants and error codes
// Purpose: error code enumeration and default cycle counts for a 12 MHz clock.
// Ports: none (package).
package ws2812_rx_pkg;

    typedef enum logic [1:0] {
        ERR_GLITCH   = 2'd0,
        ERR_TIMEOUT  = 2'd1,
        ERR_PARTIAL  = 2'd2,
        ERR_OVERFLOW = 2'd3
    } err_code_t;

    // Nominal transmit timing at 12 MHz, used by loopback partners and benches.
    localparam int T0H_CYCLES     = 4;
    localparam int T1H_CYCLES     = 8;
    localparam int BIT_PERIOD     = 15;

    localparam int DEF_NUM_LEDS   = 100;
    localparam int DEF_MIN_HIGH   = 2;
    localparam int DEF_BIT_THRESH = 6;
    localparam int DEF_MAX_HIGH   = 24;
    localparam int DEF_RESET_GAP  = 600;

endpackage

// File: rtl/ws2812_pulse_meter.sv
// rtl/ws2812_pulse_meter.sv - line synchroniser and high/low pulse width meter
// Purpose: synchronise ws_data, measure each high pulse and low run, and
//          classify events for the word assembler.
// Ports:
//   clk, reset  clock and asynchronous active-high reset
//   ws_data     raw serial line
//   bit_valid   fall of an accepted pulse (combinational from registers)
//   bit_val     decoded bit value, meaningful with bit_valid
//   glitch      fall of a too-short pulse
//   timeout     high run just exceeded the maximum width
//   gap         low run just reached the frame reset length
module ws2812_pulse_meter #(
    parameter int MIN_HIGH     = 2,
    parameter int BIT_THRESH   = 6,
    parameter int MAX_HIGH     = 24,
    parameter int RESET_CYCLES = 600
) (
    input  logic clk,
    input  logic reset,
    input  logic ws_data,
    output logic bit_valid,
    output logic bit_val,
    output logic glitch,
    output logic timeout,
    output logic gap
);

    localparam int HW = $clog2(MAX_HIGH + 2);
    localparam int LW = $clog2(RESET_CYCLES + 1);

    localparam logic [HW-1:0] H_MIN    = HW'(MIN_HIGH);
    localparam logic [HW-1:0] H_THRESH = HW'(BIT_THRESH);
    localparam logic [HW-1:0] H_MAX    = HW'(MAX_HIGH);
    localparam logic [HW-1:0] H_SAT    = HW'(MAX_HIGH + 1);
    localparam logic [LW-1:0] L_SAT    = LW'(RESET_CYCLES);
    localparam logic [LW-1:0] L_PRE    = LW'(RESET_CYCLES - 1);

    logic          sync1, sync2, dly;
    logic [HW-1:0] high_cnt;
    logic [LW-1:0] low_cnt;
    logic          rise, fall, timed_out;

    assign rise = sync2 & ~dly;
    assign fall = ~sync2 & dly;

    // high_cnt is loaded with 1 on the rise so that at the fall it equals the
    // number of clocks the synchronised line was high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            dly      <= 1'b0;
            high_cnt <= '0;
            low_cnt  <= '0;
        end else begin
            sync1 <= ws_data;
            sync2 <= sync1;
            dly   <= sync2;
            if (rise)
                high_cnt <= HW'(1);
            else if (sync2 && high_cnt != H_SAT)
                high_cnt <= high_cnt + HW'(1);
            if (rise)
                low_cnt <= '0;
            else if (!sync2 && low_cnt != L_SAT)
                low_cnt <= low_cnt + LW'(1);
        end
    end

    // A saturated count at the fall means the timeout already fired, so the
    // fall carries no bit and no glitch.
    assign timed_out = (high_cnt == H_SAT);
    assign bit_valid = fall & ~timed_out & (high_cnt >= H_MIN);
    assign glitch    = fall & ~timed_out & (high_cnt < H_MIN);
    assign bit_val   = (high_cnt >= H_THRESH);
    assign timeout   = sync2 & dly & (high_cnt == H_MAX);
    assign gap       = ~sync2 & (low_cnt == L_PRE);

endmodule

// File: rtl/ws2812_rx.sv
// rtl/ws2812_rx.sv - WS2812 one-wire receiver producing GRB words per LED
// Purpose: assemble decoded bits into 24-bit words tagged with LED index,
//          detect the frame latch gap and flag protocol errors.
// Ports:
//   clk, reset  clock and asynchronous active-high reset
//   ws_data     serial line, asynchronous to clk
//   rgb_data    last accepted word, first received bit in bit 23
//   led_num     index of rgb_data within its frame
//   valid       1-clk pulse when rgb_data/led_num update
//   latch       1-clk pulse when a frame completes
//   frame_len   words accepted in the last completed frame
//   error       1-clk pulse on a protocol error
//   err_code    code of the most recent error (held)
module ws2812_rx
    import ws2812_rx_pkg::*;
#(
    parameter int NUM_LEDS     = DEF_NUM_LEDS,
    parameter int MIN_HIGH     = DEF_MIN_HIGH,
    parameter int BIT_THRESH   = DEF_BIT_THRESH,
    parameter int MAX_HIGH     = DEF_MAX_HIGH,
    parameter int RESET_CYCLES = DEF_RESET_GAP
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ws_data,
    output logic [23:0] rgb_data,
    output logic [7:0]  led_num,
    output logic        valid,
    output logic        latch,
    output logic [7:0]  frame_len,
    output logic        error,
    output logic [1:0]  err_code
);

    localparam logic [7:0] NUM_W = 8'(NUM_LEDS);

    logic        bit_valid, bit_val, glitch, timeout, gap;
    logic [23:0] shift;
    logic [4:0]  bit_cnt;
    logic [7:0]  word_cnt;
    logic        active;
    logic        frame_end, partial, overflow, err_hit;
    err_code_t   err_val;
    logic [23:0] next_word;

    ws2812_pulse_meter #(
        .MIN_HIGH    (MIN_HIGH),
        .BIT_THRESH  (BIT_THRESH),
        .MAX_HIGH    (MAX_HIGH),
        .RESET_CYCLES(RESET_CYCLES)
    ) u_meter (
        .clk      (clk),
        .reset    (reset),
        .ws_data  (ws_data),
        .bit_valid(bit_valid),
        .bit_val  (bit_val),
        .glitch   (glitch),
        .timeout  (timeout),
        .gap      (gap)
    );

    assign next_word = {shift[22:0], bit_val};
    assign frame_end = gap & active;
    assign partial   = frame_end & (bit_cnt != 5'd0);
    assign overflow  = ~frame_end & bit_valid & (bit_cnt == 5'd23) & (word_cnt >= NUM_W);

    // Checked in ascending code order so the highest code wins.
    always_comb begin
        err_hit = 1'b0;
        err_val = ERR_GLITCH;
        if (glitch)   begin err_hit = 1'b1; err_val = ERR_GLITCH;   end
        if (timeout)  begin err_hit = 1'b1; err_val = ERR_TIMEOUT;  end
        if (partial)  begin err_hit = 1'b1; err_val = ERR_PARTIAL;  end
        if (overflow) begin err_hit = 1'b1; err_val = ERR_OVERFLOW; end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb_data  <= '0;
            led_num   <= '0;
            valid     <= 1'b0;
            latch     <= 1'b0;
            frame_len <= '0;
            error     <= 1'b0;
            err_code  <= '0;
            shift     <= '0;
            bit_cnt   <= '0;
            word_cnt  <= '0;
            active    <= 1'b0;
        end else begin
            valid <= 1'b0;
            latch <= 1'b0;
            error <= err_hit;
            if (err_hit)
                err_code <= err_val;

            if (frame_end) begin
                latch     <= 1'b1;
                frame_len <= word_cnt;
                bit_cnt   <= '0;
                word_cnt  <= '0;
                active    <= 1'b0;
            end else if (timeout) begin
                bit_cnt <= '0;
            end else if (bit_valid) begin
                shift  <= next_word;
                active <= 1'b1;
                if (bit_cnt == 5'd23) begin
                    bit_cnt <= '0;
                    if (word_cnt < NUM_W) begin
                        rgb_data <= next_word;
                        led_num  <= word_cnt;
                        valid    <= 1'b1;
                        word_cnt <= word_cnt + 8'd1;
                    end
                end else begin
                    bit_cnt <= bit_cnt + 5'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ws2812_rx.sv
// tb/tb_ws2812_rx.sv - scoreboard bench for ws2812_rx
module tb_ws2812_rx;

    localparam int EV_VALID = 0;
    localparam int EV_ERR   = 1;
    localparam int EV_LATCH = 2;

    typedef struct {
        int kind;
        int a;
        int b;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ws_data = 1'b0;
    logic [23:0] rgb_data;
    logic [7:0]  led_num;
    logic        valid;
    logic        latch;
    logic [7:0]  frame_len;
    logic        error;
    logic [1:0]  err_code;

    int total = 0;
    int bad = 0;
    ev_t exp_q[$];

    ws2812_rx dut (
        .clk      (clk),
        .reset    (reset),
        .ws_data  (ws_data),
        .rgb_data (rgb_data),
        .led_num  (led_num),
        .valid    (valid),
        .latch    (latch),
        .frame_len(frame_len),
        .error    (error),
        .err_code (err_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    task automatic push(input int kind, input int a, input int b);
        ev_t e;
        e.kind = kind;
        e.a = a;
        e.b = b;
        exp_q.push_back(e);
    endtask

    task automatic check_event(input int kind, input int a, input int b);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected event kind=%0d got a=%0h b=%0d expected none", kind, a, b);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.a != a || e.b != b) begin
                bad++;
                $display("FAIL event: got kind=%0d a=%0h b=%0d expected kind=%0d a=%0h b=%0d",
                         kind, a, b, e.kind, e.a, e.b);
            end
        end
    endtask

    // Monitor: within one cycle events are taken in order valid, error, latch.
    always @(negedge clk) begin
        if (!reset) begin
            if (valid) check_event(EV_VALID, int'(rgb_data), int'(led_num));
            if (error) check_event(EV_ERR, int'(err_code), 0);
            if (latch) check_event(EV_LATCH, int'(frame_len), 0);
        end
    end

    task automatic drive(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ws_data = v;
        end
    endtask

    task automatic send_bit(input logic b);
        drive(1'b1, b ? 8 : 4);
        drive(1'b0, b ? 7 : 11);
    endtask

    // Bit followed by a single-clock spike in its low time.
    task automatic send_bit_glitch(input logic b);
        drive(1'b1, b ? 8 : 4);
        drive(1'b0, 3);
        drive(1'b1, 1);
        drive(1'b0, b ? 3 : 7);
    endtask

    task automatic send_word(input logic [23:0] w);
        for (int i = 23; i >= 0; i--) send_bit(w[i]);
    endtask

    function automatic logic [23:0] pat(input int i);
        logic [7:0] b;
        b = 8'(i);
        return {b, ~b, b ^ 8'h5A};
    endfunction

    initial begin
        logic [23:0] w;

        // reset state
        repeat (3) @(negedge clk);
        chk("reset_rgb", int'(rgb_data), 0);
        chk("reset_led", int'(led_num), 0);
        chk("reset_valid", int'(valid), 0);
        chk("reset_latch", int'(latch), 0);
        chk("reset_len", int'(frame_len), 0);
        chk("reset_err", int'(error), 0);
        chk("reset_code", int'(err_code), 0);
        reset = 1'b0;

        // idle line must not latch
        drive(1'b0, 700);

        // single word frame
        push(EV_VALID, 24'h100000, 0);
        push(EV_LATCH, 1, 0);
        send_word(24'h100000);
        drive(1'b0, 700);

        // partial word: 12 bits then gap
        push(EV_ERR, 2, 0);
        push(EV_LATCH, 0, 0);
        for (int i = 0; i < 12; i++) send_bit(i[0]);
        drive(1'b0, 700);

        // glitch inside a word, word still decodes
        w = 24'hA5C33C;
        push(EV_ERR, 0, 0);
        push(EV_VALID, 24'hA5C33C, 0);
        push(EV_LATCH, 1, 0);
        for (int i = 23; i >= 0; i--) begin
            if (i == 10) send_bit_glitch(w[i]);
            else send_bit(w[i]);
        end
        drive(1'b0, 700);

        // stuck-high timeout aborts word, next word starts fresh
        push(EV_ERR, 1, 0);
        push(EV_VALID, 24'h5A0F81, 0);
        push(EV_LATCH, 1, 0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        drive(1'b1, 30);
        drive(1'b0, 10);
        send_word(24'h5A0F81);
        drive(1'b0, 700);

        // 101 words: 100 accepted, overflow on the last
        for (int i = 0; i < 100; i++) push(EV_VALID, int'(pat(i)), i);
        push(EV_ERR, 3, 0);
        push(EV_LATCH, 100, 0);
        for (int i = 0; i < 101; i++) send_word(pat(i));
        drive(1'b0, 700);
        chk("ovf_led_hold", int'(led_num), 99);
        chk("ovf_rgb_hold", int'(rgb_data), int'(pat(99)));
        chk("ovf_len", int'(frame_len), 100);
        chk("ovf_code_hold", int'(err_code), 3);

        // reset mid-word
        w = 24'hC3F00F;
        for (int i = 23; i >= 14; i--) send_bit(w[i]);
        @(negedge clk);
        ws_data = 1'b0;
        reset = 1'b1;
        #1;
        chk("midrst_rgb", int'(rgb_data), 0);
        chk("midrst_led", int'(led_num), 0);
        chk("midrst_len", int'(frame_len), 0);
        chk("midrst_code", int'(err_code), 0);
        chk("midrst_valid", int'(valid), 0);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 20);
        push(EV_VALID, 24'h0FF033, 0);
        push(EV_LATCH, 1, 0);
        send_word(24'h0FF033);
        drive(1'b0, 700);

        drive(1'b0, 20);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL pending_events: got %0d left expected 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
